// File: rtl/mshr_file_pkg.sv
// Shared types for the MSHR file: memory-bus encodings, entry layout, and the
// helper that places store data into its lane of a 64-bit block.
package mshr_file_pkg;

  localparam int MSHR_DEPTH = 4;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [63:0] mem_block_t;
  typedef logic [3:0]  mem_tag_t;

  typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} mem_size_t;
  typedef enum logic [1:0] {MEM_NONE = 2'h0, MEM_LOAD = 2'h1, MEM_STORE = 2'h2} mem_command_t;

  localparam logic [1:0] MSHR_INVALID   = 2'd0;
  localparam logic [1:0] MSHR_PENDING   = 2'd1;
  localparam logic [1:0] MSHR_WAIT_DATA = 2'd2;
  localparam logic [1:0] MSHR_WRITEBACK = 2'd3;

  typedef struct packed {
    logic [1:0] state;
    addr_t      addr;
    data_t      data;
    mem_size_t  st_size;
    logic       is_store;
    mem_tag_t   mem_tag;
  } mshr_entry_t;

  function automatic mem_block_t place_store(input logic [2:0] offset, input data_t data,
                                             input mem_size_t size);
    mem_block_t blk;
    case (size)
      BYTE:    blk = {56'b0, data[7:0]};
      HALF:    blk = {48'b0, data[15:0]};
      default: blk = {32'b0, data};
    endcase
    return blk << {offset, 3'b000};
  endfunction

endpackage

// File: rtl/mshr_file_if.sv
// Bundle of request, memory-bus and refill signals between the MSHR file and its neighbours.
interface mshr_file_if;
  import mshr_file_pkg::*;

  // Requests are valid/accept: the unit holds a miss (valid, address, data) stable
  // until a cycle where accept=1; accept=0 with valid=1 means retry next cycle.
  logic         valid;
  addr_t        in_addr;
  data_t        in_data;
  mem_size_t    st_size;
  logic         is_store;
  logic         Dcache_hit;
  mem_tag_t     mem2proc_transaction_tag;
  mem_tag_t     mem2proc_data_tag;
  mem_block_t   mem2proc_data;
  mem_command_t proc2mem_command;
  addr_t        proc2mem_addr;
  mem_block_t   proc2mem_data;
  mem_size_t    proc2mem_size;
  logic         mshr2cache_wr;
  addr_t        mshr2cache_addr;
  mem_block_t   mshr2cache_block;
  logic         mshr2cache_is_store;
  data_t        mshr2cache_data;
  mem_size_t    mshr2cache_st_size;
  logic         accept;
  logic         stall;

  modport slave (
    input  valid, in_addr, in_data, st_size, is_store, Dcache_hit,
           mem2proc_transaction_tag, mem2proc_data_tag, mem2proc_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
           mshr2cache_wr, mshr2cache_addr, mshr2cache_block, mshr2cache_is_store,
           mshr2cache_data, mshr2cache_st_size, accept, stall
  );

  modport master (
    output valid, in_addr, in_data, st_size, is_store, Dcache_hit,
           mem2proc_transaction_tag, mem2proc_data_tag, mem2proc_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
           mshr2cache_wr, mshr2cache_addr, mshr2cache_block, mshr2cache_is_store,
           mshr2cache_data, mshr2cache_st_size, accept, stall
  );
endinterface

// File: rtl/mshr_lowest_sel.sv
// Lowest-index one-hot selector: grants the least significant set request bit.
module mshr_lowest_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);
  assign gnt = req & (~req + N'(1));
  assign any = |req;
endmodule

// File: rtl/mshr_file.sv
// Non-blocking MSHR file: allocates misses, issues one memory command per cycle,
// matches returning tags and drives refills. MSHR_MERGE_EN enables same-block load merging.
module mshr_file
  import mshr_file_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  mshr_file_if.slave  bus,
  output mshr_entry_t debug_mshrs [MSHR_DEPTH]
);

  mshr_entry_t mshrs_q [MSHR_DEPTH];
  mshr_entry_t mshrs_d [MSHR_DEPTH];

  logic [MSHR_DEPTH-1:0] free_req, pend_req, wb_req;
  logic [MSHR_DEPTH-1:0] free_gnt, pend_gnt, wb_gnt;
  logic free_any, pend_any, wb_any;
  logic merge_hit, alloc;

  always_comb begin
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      free_req[i] = (mshrs_q[i].state == MSHR_INVALID);
      pend_req[i] = (mshrs_q[i].state == MSHR_PENDING);
      wb_req[i]   = (mshrs_q[i].state == MSHR_WRITEBACK);
    end
  end

  mshr_lowest_sel #(.N(MSHR_DEPTH)) u_free_sel (.req(free_req), .gnt(free_gnt), .any(free_any));
  mshr_lowest_sel #(.N(MSHR_DEPTH)) u_pend_sel (.req(pend_req), .gnt(pend_gnt), .any(pend_any));
  mshr_lowest_sel #(.N(MSHR_DEPTH)) u_wb_sel   (.req(wb_req),   .gnt(wb_gnt),   .any(wb_any));

`ifdef MSHR_MERGE_EN
  // Only load-only entries still awaiting their refill can absorb another load.
  always_comb begin
    merge_hit = 1'b0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if ((mshrs_q[i].state == MSHR_PENDING || mshrs_q[i].state == MSHR_WAIT_DATA) &&
          !mshrs_q[i].is_store && mshrs_q[i].addr[31:3] == bus.in_addr[31:3])
        merge_hit = 1'b1;
    end
    merge_hit = merge_hit && bus.valid && !bus.Dcache_hit && !bus.is_store;
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign bus.stall  = !free_any;
  assign alloc      = bus.valid && !bus.Dcache_hit && free_any && !merge_hit;
  assign bus.accept = alloc || merge_hit;

  always_comb begin
    mshrs_d                 = mshrs_q;
    bus.proc2mem_command    = MEM_NONE;
    bus.proc2mem_addr       = '0;
    bus.proc2mem_data       = '0;
    bus.proc2mem_size       = BYTE;
    bus.mshr2cache_wr       = 1'b0;
    bus.mshr2cache_addr     = '0;
    bus.mshr2cache_block    = '0;
    bus.mshr2cache_is_store = 1'b0;
    bus.mshr2cache_data     = '0;
    bus.mshr2cache_st_size  = BYTE;

    // Write-through stores own the bus; a pending load waits behind them.
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (wb_gnt[i]) begin
        bus.proc2mem_command = MEM_STORE;
        bus.proc2mem_addr    = mshrs_q[i].addr;
        bus.proc2mem_size    = mshrs_q[i].st_size;
        bus.proc2mem_data    = place_store(mshrs_q[i].addr[2:0], mshrs_q[i].data,
                                           mshrs_q[i].st_size);
        mshrs_d[i].state     = MSHR_INVALID;
      end else if (pend_gnt[i] && !wb_any) begin
        bus.proc2mem_command = MEM_LOAD;
        bus.proc2mem_addr    = {mshrs_q[i].addr[31:3], 3'b000};
        bus.proc2mem_size    = DOUBLE;
        if (bus.mem2proc_transaction_tag != '0) begin
          mshrs_d[i].state   = MSHR_WAIT_DATA;
          mshrs_d[i].mem_tag = bus.mem2proc_transaction_tag;
        end
      end
    end

    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (mshrs_q[i].state == MSHR_WAIT_DATA && bus.mem2proc_data_tag != '0 &&
          mshrs_q[i].mem_tag == bus.mem2proc_data_tag) begin
        bus.mshr2cache_wr       = 1'b1;
        bus.mshr2cache_addr     = mshrs_q[i].addr;
        bus.mshr2cache_block    = bus.mem2proc_data;
        bus.mshr2cache_is_store = mshrs_q[i].is_store;
        if (mshrs_q[i].is_store) begin
          bus.mshr2cache_data    = mshrs_q[i].data;
          bus.mshr2cache_st_size = mshrs_q[i].st_size;
        end
        mshrs_d[i].state = mshrs_q[i].is_store ? MSHR_WRITEBACK : MSHR_INVALID;
      end
    end

    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (alloc && free_gnt[i]) begin
        mshrs_d[i].state    = MSHR_PENDING;
        mshrs_d[i].addr     = bus.in_addr;
        mshrs_d[i].data     = bus.in_data;
        mshrs_d[i].st_size  = bus.st_size;
        mshrs_d[i].is_store = bus.is_store;
        mshrs_d[i].mem_tag  = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_DEPTH; i++) mshrs_q[i] <= '0;
    end else begin
      mshrs_q <= mshrs_d;
    end
  end

  assign debug_mshrs = mshrs_q;

endmodule

// File: tb/tb_mshr_file.sv
// Self-checking bench for mshr_file: directed scenarios plus a short random load sweep.
module tb_mshr_file;
  import mshr_file_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  mshr_file_if bus();
  mshr_entry_t debug_mshrs [MSHR_DEPTH];

  mshr_file dut (.clock(clock), .reset(reset), .bus(bus), .debug_mshrs(debug_mshrs));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [130:0] exp_q[$];
  logic [130:0] fill_q[$];

  task automatic check(input string tag, input logic [130:0] obs, input logic [130:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [130:0] cmd_pkt(input logic [1:0] cmd, input addr_t a,
                                           input logic [1:0] sz, input mem_block_t d);
    logic [130:0] r;
    r = '0;
    r[99:0] = {cmd, a, sz, d};
    return r;
  endfunction

  function automatic logic [130:0] fill_pkt(input addr_t a, input logic st, input data_t d,
                                            input logic [1:0] sz, input mem_block_t blk);
    return {a, st, d, sz, blk};
  endfunction

  // Monitor: every bus command and refill must match the next scoreboard entry.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.proc2mem_command != MEM_NONE) begin
        if (exp_q.size() == 0)
          check("cmd_unexpected", cmd_pkt(bus.proc2mem_command, bus.proc2mem_addr,
                bus.proc2mem_size, bus.proc2mem_data), '0);
        else
          check("cmd", cmd_pkt(bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_size,
                bus.proc2mem_data), exp_q.pop_front());
      end
      if (bus.mshr2cache_wr) begin
        if (fill_q.size() == 0)
          check("fill_unexpected", {bus.mshr2cache_addr, 99'b0}, '0);
        else
          check("fill", fill_pkt(bus.mshr2cache_addr, bus.mshr2cache_is_store,
                bus.mshr2cache_data, bus.mshr2cache_st_size, bus.mshr2cache_block),
                fill_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic drive_idle();
    bus.valid = 1'b0;
    bus.in_addr = '0;
    bus.in_data = '0;
    bus.st_size = BYTE;
    bus.is_store = 1'b0;
    bus.Dcache_hit = 1'b0;
    bus.mem2proc_transaction_tag = '0;
    bus.mem2proc_data_tag = '0;
    bus.mem2proc_data = '0;
  endtask

  task automatic drive_miss(input addr_t a, input logic st, input data_t d, input mem_size_t sz);
    bus.valid = 1'b1;
    bus.in_addr = a;
    bus.is_store = st;
    bus.in_data = d;
    bus.st_size = sz;
    bus.Dcache_hit = 1'b0;
  endtask

  task automatic push_load(input addr_t a);
    exp_q.push_back(cmd_pkt(MEM_LOAD, {a[31:3], 3'b000}, DOUBLE, '0));
  endtask

  task automatic do_load_fill(input mem_tag_t tag, input addr_t a);
    mem_block_t blk;
    blk = {$urandom, $urandom};
    bus.mem2proc_data_tag = tag;
    bus.mem2proc_data = blk;
    fill_q.push_back(fill_pkt(a, 1'b0, '0, BYTE, blk));
    settle();
    next_cycle();
    bus.mem2proc_data_tag = '0;
    bus.mem2proc_data = '0;
  endtask

  initial begin
    mem_block_t blk;
    addr_t a;
    mem_tag_t t;

    drive_idle();
    reset = 1'b1;
    next_cycle();
    settle();
    check("rst_cmd", bus.proc2mem_command, MEM_NONE);
    check("rst_wr", bus.mshr2cache_wr, 1'b0);
    check("rst_accept", bus.accept, 1'b0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_addr", {bus.proc2mem_addr, bus.proc2mem_data, bus.mshr2cache_addr}, '0);
    check("rst_e0", debug_mshrs[0], '0);
    next_cycle();
    reset = 1'b0;

    // Single load miss, issue, refill.
    drive_miss(32'h100, 1'b0, '0, BYTE);
    bus.mem2proc_transaction_tag = 4'd3;
    push_load(32'h100);
    settle();
    check("s1_accept", bus.accept, 1'b1);
    check("s1_no_cmd_same_cycle", bus.proc2mem_command, MEM_NONE);
    next_cycle();
    bus.valid = 1'b0;
    settle();
    next_cycle();
    bus.mem2proc_transaction_tag = '0;
    settle();
    check("s1_wait_state", {debug_mshrs[0].state, debug_mshrs[0].mem_tag}, {MSHR_WAIT_DATA, 4'd3});
    do_load_fill(4'd3, 32'h100);
    settle();
    check("s1_freed", debug_mshrs[0].state, MSHR_INVALID);
    next_cycle();

    // Fill all four entries, then a fifth miss stalls until tag 2 returns.
    for (int i = 0; i < 5; i++) begin
      drive_miss(32'(i * 8), 1'b0, '0, BYTE);
      bus.mem2proc_transaction_tag = 4'(i);
      if (i < 4) push_load(32'(i * 8));
      settle();
      if (i < 4) check("s2_accept", bus.accept, 1'b1);
      else check("s2_full", {bus.stall, bus.accept}, 2'b10);
      next_cycle();
    end
    bus.mem2proc_transaction_tag = '0;
    blk = {$urandom, $urandom};
    bus.mem2proc_data_tag = 4'd2;
    bus.mem2proc_data = blk;
    fill_q.push_back(fill_pkt(32'h8, 1'b0, '0, BYTE, blk));
    settle();
    check("s2_stall_on_free_cycle", {bus.stall, bus.accept}, 2'b10);
    next_cycle();
    bus.mem2proc_data_tag = '0;
    push_load(32'h20);
    settle();
    check("s2_accept_after_free", {bus.stall, bus.accept}, 2'b01);
    next_cycle();
    bus.valid = 1'b0;
    bus.mem2proc_transaction_tag = 4'd5;
    settle();
    check("s2_e1_realloc", {debug_mshrs[1].state, debug_mshrs[1].addr}, {MSHR_PENDING, 32'h20});
    next_cycle();
    bus.mem2proc_transaction_tag = '0;
    do_load_fill(4'd1, 32'h0);
    do_load_fill(4'd3, 32'h10);
    do_load_fill(4'd4, 32'h18);
    do_load_fill(4'd5, 32'h20);

    // Transaction tag 0 twice, then 5: three LOADs on the same address.
    drive_miss(32'h40, 1'b0, '0, BYTE);
    push_load(32'h40);
    push_load(32'h40);
    push_load(32'h40);
    settle();
    next_cycle();
    bus.valid = 1'b0;
    settle();
    next_cycle();
    settle();
    next_cycle();
    bus.mem2proc_transaction_tag = 4'd5;
    settle();
    next_cycle();
    bus.mem2proc_transaction_tag = '0;
    settle();
    check("s3_wait_tag5", {debug_mshrs[0].state, debug_mshrs[0].mem_tag}, {MSHR_WAIT_DATA, 4'd5});
    check("s3_no_more_cmd", bus.proc2mem_command, MEM_NONE);
    next_cycle();
    do_load_fill(4'd5, 32'h40);

    // Store miss: refill carries store fields, then MEM_STORE defers a pending load.
    drive_miss(32'h204, 1'b1, 32'hDEADBEEF, WORD);
    push_load(32'h204);
    settle();
    check("s4_accept", bus.accept, 1'b1);
    next_cycle();
    bus.valid = 1'b0;
    bus.is_store = 1'b0;
    bus.mem2proc_transaction_tag = 4'd7;
    settle();
    next_cycle();
    bus.mem2proc_transaction_tag = '0;
    drive_miss(32'h400, 1'b0, '0, BYTE);
    blk = {$urandom, $urandom};
    bus.mem2proc_data_tag = 4'd7;
    bus.mem2proc_data = blk;
    fill_q.push_back(fill_pkt(32'h204, 1'b1, 32'hDEADBEEF, WORD, blk));
    exp_q.push_back(cmd_pkt(MEM_STORE, 32'h204, WORD, 64'hDEADBEEF_00000000));
    push_load(32'h400);
    settle();
    check("s4_refill_wr", bus.mshr2cache_wr, 1'b1);
    next_cycle();
    bus.valid = 1'b0;
    bus.mem2proc_data_tag = '0;
    bus.mem2proc_transaction_tag = 4'd8;
    settle();
    check("s4_store_first", bus.proc2mem_command, MEM_STORE);
    next_cycle();
    settle();
    check("s4_load_deferred", bus.proc2mem_command, MEM_LOAD);
    next_cycle();
    bus.mem2proc_transaction_tag = '0;
    settle();
    check("s4_e0_free", debug_mshrs[0].state, MSHR_INVALID);
    check("s4_e1_wait", {debug_mshrs[1].state, debug_mshrs[1].mem_tag}, {MSHR_WAIT_DATA, 4'd8});
    next_cycle();
    do_load_fill(4'd8, 32'h400);

    // Two loads to the same block.
    drive_miss(32'h300, 1'b0, '0, BYTE);
    push_load(32'h300);
    settle();
    check("s5_accept0", bus.accept, 1'b1);
    next_cycle();
    drive_miss(32'h304, 1'b0, '0, BYTE);
    bus.mem2proc_transaction_tag = 4'd9;
`ifndef MSHR_MERGE_EN
    push_load(32'h304);
`endif
    settle();
    check("s5_accept1", bus.accept, 1'b1);
    next_cycle();
    bus.valid = 1'b0;
    bus.mem2proc_transaction_tag = 4'd10;
    settle();
    next_cycle();
    bus.mem2proc_transaction_tag = '0;
    settle();
`ifdef MSHR_MERGE_EN
    check("s5_e1_unused", debug_mshrs[1].state, MSHR_INVALID);
`else
    check("s5_e1_used", {debug_mshrs[1].state, debug_mshrs[1].mem_tag}, {MSHR_WAIT_DATA, 4'd10});
`endif
    next_cycle();
    do_load_fill(4'd9, 32'h300);
`ifndef MSHR_MERGE_EN
    do_load_fill(4'd10, 32'h304);
`endif

    // Random single loads.
    for (int k = 0; k < 4; k++) begin
      a = 32'h1000 + (32'($urandom_range(0, 255)) << 3) + 32'($urandom_range(0, 7));
      t = 4'($urandom_range(1, 15));
      drive_miss(a, 1'b0, '0, BYTE);
      push_load(a);
      settle();
      check("rnd_accept", {bus.stall, bus.accept}, 2'b01);
      next_cycle();
      bus.valid = 1'b0;
      bus.mem2proc_transaction_tag = t;
      settle();
      next_cycle();
      bus.mem2proc_transaction_tag = '0;
      do_load_fill(t, a);
    end

    // Reset with two entries outstanding drops them.
    drive_miss(32'h500, 1'b0, '0, BYTE);
    push_load(32'h500);
    settle();
    next_cycle();
    drive_miss(32'h508, 1'b0, '0, BYTE);
    bus.mem2proc_transaction_tag = 4'd11;
    push_load(32'h508);
    settle();
    next_cycle();
    bus.valid = 1'b0;
    bus.mem2proc_transaction_tag = 4'd12;
    settle();
    next_cycle();
    bus.mem2proc_transaction_tag = '0;
    settle();
    check("s6_two_wait", {debug_mshrs[0].state, debug_mshrs[1].state}, {MSHR_WAIT_DATA, MSHR_WAIT_DATA});
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.mem2proc_data_tag = 4'd11;
    bus.mem2proc_data = {$urandom, $urandom};
    settle();
    check("s6_no_fill_tag11", bus.mshr2cache_wr, 1'b0);
    check("s6_stall_clear", bus.stall, 1'b0);
    next_cycle();
    bus.mem2proc_data_tag = 4'd12;
    settle();
    check("s6_no_fill_tag12", bus.mshr2cache_wr, 1'b0);
    next_cycle();
    drive_idle();
    settle();

    check("cmd_q_drained", 131'(exp_q.size()), '0);
    check("fill_q_drained", 131'(fill_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mshr_file.md
# mshr_file

Multi-entry, non-blocking miss status holding register file that sits between the load/store units, the Dcache and the memory bus. Each Dcache miss is tracked in one of `MSHR_DEPTH` entries, so several loads/stores can be outstanding at once. The block arbitrates a single memory command per cycle, matches returning data tags against all outstanding entries, and drives the refill (and store merge info) into the Dcache. A write-through `MEM_STORE` follows each store refill.

## Interface
- `MSHR_DEPTH`, 4, number of entries; power of two, ≥2
- `clock` in 1: single clock
- `reset` in 1: synchronous, active-high
- `valid` in 1: request from load/store unit this cycle
- `in_addr` in `ADDR`: request byte address
- `in_data` in `DATA`: store data
- `st_size` in `MEM_SIZE`: store size
- `is_store` in 1: request is a store
- `Dcache_hit` in 1: Dcache hit for `in_addr` this cycle
- `mem2proc_transaction_tag` in `MEM_TAG`: nonzero means the command issued this cycle was accepted
- `mem2proc_data_tag` in `MEM_TAG`: tag of the returning block; 0 means none
- `mem2proc_data` in `MEM_BLOCK`: returning block
- `proc2mem_command` out `MEM_COMMAND`: `MEM_NONE`/`MEM_LOAD`/`MEM_STORE`
- `proc2mem_addr` out `ADDR`: command address, block-aligned for loads
- `proc2mem_data` out `MEM_BLOCK`: store data, lane-placed
- `proc2mem_size` out `MEM_SIZE`: `DOUBLE` for loads, entry size for stores
- `mshr2cache_wr` out 1: refill write this cycle
- `mshr2cache_addr` out `ADDR`: refill address
- `mshr2cache_block` out `MEM_BLOCK`: refill data
- `mshr2cache_is_store`, `mshr2cache_data`, `mshr2cache_st_size` out 1/`DATA`/`MEM_SIZE`: store to merge into the refilled line
- `accept` out 1: request captured or merged this cycle
- `stall` out 1: no free entry

## Operation
- Entry states `MSHR_INVALID`, `MSHR_PENDING`, `MSHR_WAIT_DATA`, `MSHR_WRITEBACK`. Each entry holds state, addr, data, st_size, is_store and mem_tag.
- **Allocate:** when `valid && !Dcache_hit && !stall`, the lowest-index `MSHR_INVALID` entry captures the request and goes to `MSHR_PENDING`. `accept=1`.
- **Full:** `stall=1` while all entries are non-INVALID. A miss presented while full gets `accept=0` and no state change; the requester holds it.
- **Issue:** the lowest-index `MSHR_PENDING` entry drives `MEM_LOAD` on `addr & ~7`.
  - Transaction tag nonzero: the tag is latched and the entry moves to `MSHR_WAIT_DATA`.
  - Tag 0: the entry stays `MSHR_PENDING` and retries next cycle.
- **Fill:** every cycle `mem2proc_data_tag != 0` is compared against all `MSHR_WAIT_DATA` tags; at most one matches.
  - Match: `mshr2cache_wr=1` with the entry's addr and `mem2proc_data`, plus the store fields if `is_store`.
  - Next state: `MSHR_WRITEBACK` if store, else `MSHR_INVALID`.
- **Writeback:** the lowest-index `MSHR_WRITEBACK` entry drives `MEM_STORE` (addr, size, data placed by `addr[2:0]`). Stores are always accepted; the entry goes to `MSHR_INVALID`.
- **Command priority:** `MEM_STORE` beats `MEM_LOAD`. The loser holds its state.
- **Hit bypass:** `Dcache_hit` or `!valid` means no allocation and `accept=0`.

## Timing
- Reset: all entries `MSHR_INVALID` and mem_tag 0. Outputs: `proc2mem_command=MEM_NONE`, `mshr2cache_wr=0`, `accept=0`, `stall=0`, all data/address outputs 0.
- Outputs are combinational from registered state plus current inputs. State updates on `posedge clock`.
- Latency:
  - miss at cycle t → `MEM_LOAD` at t+1 at the earliest;
  - matching data tag at cycle u → `mshr2cache_wr` in cycle u;
  - store `MEM_STORE` at u+1 at the earliest.
- An entry freed in cycle t is allocatable at t+1, not at t. `stall` reflects start-of-cycle occupancy.
- Fill and allocate/issue in the same cycle are independent and all take effect.
- Reset mid-operation drops every entry. Later data tags match nothing and are ignored.
- Default outputs when idle: `MEM_NONE`, zeros; no latches.

## Configuration
- `MSHR_MERGE_EN` defined:
  - A load miss whose block (`addr[31:3]`) equals a `MSHR_PENDING`/`MSHR_WAIT_DATA` entry's block and whose entry is a load gets `accept=1`, no allocation and no extra `MEM_LOAD`. The unit re-probes after the refill.
  - Merging is allowed even when full.
  - Store misses never merge.
- Undefined: no address comparison. Every miss allocates, and duplicate `MEM_LOAD`s to the same block are allowed.

## Structure
- `sys_defs.svh`:
  - `MSHR_STATE` enum, with `MSHR_INVALID=0`;
  - `MSHR_ENTRY` struct;
  - `` `define MSHR_DEPTH 4 ``.
- Sub-module `mshr_lowest_sel`: a parametrised lowest-index one-hot selector, instantiated three times (free, pending, writeback).
- The existing `DEBUG` macro exposes `debug_mshrs[MSHR_DEPTH]`.

## Test plan
- Reset, then `valid=1`, `Dcache_hit=0`, `in_addr=0x100`, load, transaction tag 3 → `MEM_LOAD` addr 0x100 next cycle; data tag 3 later → `mshr2cache_wr=1` addr 0x100, entry freed.
- Four misses at 0x0/0x8/0x10/0x18 with tags 1–4, then a fifth miss → `stall=1`, `accept=0`. Data tag 2 → fifth accepted the next cycle into entry 1.
- Transaction tag 0 on two cycles, then 5 → `MEM_LOAD` repeated on the same addr three cycles, entry in `MSHR_WAIT_DATA` with tag 5.
- Store `WORD` 0xDEADBEEF to 0x204, tag 7, data tag 7 → refill with store fields set; next cycle `MEM_STORE` addr 0x204 size `WORD`. A pending load's `MEM_LOAD` is deferred one cycle.
- `MSHR_MERGE_EN`: loads to 0x300 then 0x304 → one `MEM_LOAD`, both `accept=1`, one entry used. Without the macro: two entries, two `MEM_LOAD`s.
- Reset while two entries are in `MSHR_WAIT_DATA` → the next data tag causes no `mshr2cache_wr`, `stall=0`.
